// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared encodings for the multicycle MIPS main control unit:
//   opcodes, ALUOp values seen by the ALU control decoder, ALUSrcB and
//   PCSource mux selects, the controller state enum, the latched
//   instruction class and the packed datapath control vector.
package mips_ctrl_pkg;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   // ALUOp values; these must match the ALU control decoder
   localparam logic [2:0] ALUOP_AND    = 3'b000;
   localparam logic [2:0] ALUOP_BRANCH = 3'b001;
   localparam logic [2:0] ALUOP_ADD    = 3'b100;
   localparam logic [2:0] ALUOP_OR     = 3'b101;
   localparam logic [2:0] ALUOP_RTYPE  = 3'b111;

   // ALUSrcB selects
   localparam logic [1:0] SRCB_REG    = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   // PCSource selects
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALU_WB,
      S_BRANCH,
      S_JUMP,
      S_TRAP
   } state_e;

   // The class register is interpreted by the path the FSM is on:
   // in EXEC_I it picks the ALU operation, in ALU_WB it selects RegDst,
   // and in MEM_ADDR it separates loads from stores.
   typedef enum logic [1:0] {
      CLS_R   = 2'd0,
      CLS_ADD = 2'd1,
      CLS_OR  = 2'd2,
      CLS_AND = 2'd3
   } cls_e;

   localparam cls_e CLS_LOAD  = CLS_ADD;
   localparam cls_e CLS_STORE = CLS_OR;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
   } ctrl_t;

   function automatic cls_e opcode_class(input logic [5:0] op);
      cls_e c;
      c = CLS_R;
      case (op)
         OP_ADDI: c = CLS_ADD;
         OP_ORI:  c = CLS_OR;
         OP_ANDI: c = CLS_AND;
         OP_LW:   c = CLS_LOAD;
         OP_SW:   c = CLS_STORE;
         default: c = CLS_R;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_output_decoder.sv
// control_output_decoder
//   Purely combinational map from {state, latched class, MemReady} to
//   the datapath control vector. Everything not driven by a state is 0.
// Ports:
//   state     in  current controller state
//   cls       in  instruction class latched in DECODE
//   mem_ready in  memory completed the access this cycle
//   ctrl      out packed datapath controls
module control_output_decoder
   import mips_ctrl_pkg::*;
(
   input  state_e state,
   input  cls_e   cls,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            // Latch the instruction and commit PC+4 only in the cycle the
            // memory returns data.
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_READ: begin
            ctrl.ior_d    = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.ior_d     = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_RTYPE;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            case (cls)
               CLS_OR:  ctrl.alu_op = ALUOP_OR;
               CLS_AND: ctrl.alu_op = ALUOP_AND;
               default: ctrl.alu_op = ALUOP_ADD;
            endcase
         end
         S_ALU_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = (cls == CLS_R);
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_op        = ALUOP_BRANCH;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multicycle MIPS main control FSM. Sequences each instruction through
//   fetch/decode/execute/memory/write-back, handshaking with a
//   variable-latency memory via MemReady. Holds the state register,
//   next-state logic, instruction-class latch and sticky Illegal flag;
//   output decoding lives in control_output_decoder.
// Ports:
//   clk, reset (async, active-low)
//   Opcode[5:0]  instr[31:26] from IR, sampled in DECODE only
//   Zero         ALU zero flag (gated with PCWriteCond in the datapath)
//   MemReady     memory access completes this cycle
//   PCWrite..ALUSrcA, ALUSrcB[1:0], PCSource[1:0], ALUOp[2:0]  controls
//   Illegal      sticky unknown-opcode flag, cleared only by reset
module multicycle_control
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [2:0] ALUOp,
   output logic       Illegal
);

   state_e state_q, state_d;
   cls_e   cls_q;
   logic   illegal_q;
   ctrl_t  ctrl;

   // The branch decision is made in the datapath; Zero is not needed here.
   logic   unused_zero;
   assign unused_zero = Zero;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cls_q     <= CLS_R;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE)
            cls_q <= opcode_class(Opcode);
         if (state_d == S_TRAP)
            illegal_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (MemReady) state_d = S_DECODE;
         S_DECODE: begin
            case (Opcode)
               OP_LW, OP_SW:             state_d = S_MEM_ADDR;
               OP_R:                     state_d = S_EXEC_R;
               OP_ADDI, OP_ORI, OP_ANDI: state_d = S_EXEC_I;
               OP_BEQ:                   state_d = S_BRANCH;
               OP_J:                     state_d = S_JUMP;
               default:                  state_d = S_TRAP;
            endcase
         end
         S_MEM_ADDR:  state_d = (cls_q == CLS_STORE) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (MemReady) state_d = S_MEM_WB;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: if (MemReady) state_d = S_FETCH;
         S_EXEC_R:    state_d = S_ALU_WB;
         S_EXEC_I:    state_d = S_ALU_WB;
         S_ALU_WB:    state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         S_TRAP:      state_d = S_TRAP;
         default:     state_d = S_IDLE;
      endcase
   end

   control_output_decoder u_dec (
      .state     (state_q),
      .cls       (cls_q),
      .mem_ready (MemReady),
      .ctrl      (ctrl)
   );

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.ior_d;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign IRWrite     = ctrl.ir_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign RegDst      = ctrl.reg_dst;
   assign RegWrite    = ctrl.reg_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign PCSource    = ctrl.pc_source;
   assign ALUOp       = ctrl.alu_op;
   assign Illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Table-driven bench for multicycle_control: one record per clock cycle
//   holding the inputs and the hand-written expected output vector, plus
//   hand-written reset sequences.
//   Output vector layout (MSB..LSB):
//   PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
//   RegWrite ALUSrcA ALUSrcB[2] PCSource[2] ALUOp[3] Illegal
module tb_multicycle_control;

   logic       clk;
   logic       reset;
   logic [5:0] Opcode;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUOp;

   int checks   = 0;
   int failures = 0;

   //                              PW PWC IoD MR MW IRW M2R RD RW ASA  B   PCS  OP  ILL
   localparam logic [17:0] E_ZERO  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_000_0;
   localparam logic [17:0] E_FWAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_100_0;
   localparam logic [17:0] E_FRDY  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_100_0;
   localparam logic [17:0] E_DEC   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_100_0;
   localparam logic [17:0] E_MADDR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_100_0;
   localparam logic [17:0] E_MREAD = 18'b0_0_1_1_0_0_0_0_0_0_00_00_000_0;
   localparam logic [17:0] E_MWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_000_0;
   localparam logic [17:0] E_MWR   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_000_0;
   localparam logic [17:0] E_EXR   = 18'b0_0_0_0_0_0_0_0_0_1_00_00_111_0;
   localparam logic [17:0] E_ADDI  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_100_0;
   localparam logic [17:0] E_ORI   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_101_0;
   localparam logic [17:0] E_ANDI  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_000_0;
   localparam logic [17:0] E_WBR   = 18'b0_0_0_0_0_0_0_1_1_0_00_00_000_0;
   localparam logic [17:0] E_WBI   = 18'b0_0_0_0_0_0_0_0_1_0_00_00_000_0;
   localparam logic [17:0] E_BR    = 18'b0_1_0_0_0_0_0_0_0_1_00_01_001_0;
   localparam logic [17:0] E_JMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_10_000_0;
   localparam logic [17:0] E_TRAP  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_000_1;

   typedef struct {
      logic [5:0]  op;
      logic        mr;
      logic [17:0] exp;
      string       name;
   } vec_t;

   vec_t vq[$];

   multicycle_control dut (
      .clk         (clk),
      .reset       (reset),
      .Opcode      (Opcode),
      .Zero        (Zero),
      .MemReady    (MemReady),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemtoReg    (MemtoReg),
      .RegDst      (RegDst),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .PCSource    (PCSource),
      .ALUOp       (ALUOp),
      .Illegal     (Illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   function automatic logic [17:0] outs();
      return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
              RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal};
   endfunction

   task automatic check(input string name, input logic [17:0] exp);
      logic [17:0] got;
      got = outs();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic mr,
                      input logic [17:0] exp, input string name);
      vec_t v;
      v.op = op; v.mr = mr; v.exp = exp; v.name = name;
      vq.push_back(v);
   endtask

   // Apply one cycle of inputs after the falling edge and compare #1 later.
   task automatic step(input logic [5:0] op, input logic mr,
                       input logic [17:0] exp, input string name);
      @(negedge clk);
      Opcode   = op;
      MemReady = mr;
      Zero     = 1'($urandom_range(0, 1));
      #1;
      check(name, exp);
   endtask

   initial begin
      // R-type; opcode disturbed after DECODE must not matter
      add(6'h00, 1'b1, E_FRDY,  "r_fetch");
      add(6'h00, 1'b1, E_DEC,   "r_decode");
      add(6'h3f, 1'b1, E_EXR,   "r_exec");
      add(6'h3f, 1'b0, E_WBR,   "r_wb");
      // LW, three wait cycles in MEM_READ: 8 cycles total
      add(6'h23, 1'b1, E_FRDY,  "lw_fetch");
      add(6'h23, 1'b1, E_DEC,   "lw_decode");
      add(6'h23, 1'b1, E_MADDR, "lw_addr");
      add(6'h23, 1'b0, E_MREAD, "lw_read_w1");
      add(6'h23, 1'b0, E_MREAD, "lw_read_w2");
      add(6'h23, 1'b0, E_MREAD, "lw_read_w3");
      add(6'h23, 1'b1, E_MREAD, "lw_read_rdy");
      add(6'h23, 1'b0, E_MWB,   "lw_wb");
      // ORI with one fetch wait; opcode changed in ALU_WB
      add(6'h0d, 1'b0, E_FWAIT, "ori_fetch_wait");
      add(6'h0d, 1'b1, E_FRDY,  "ori_fetch");
      add(6'h0d, 1'b1, E_DEC,   "ori_decode");
      add(6'h0d, 1'b1, E_ORI,   "ori_exec");
      add(6'h00, 1'b1, E_WBI,   "ori_wb");
      // ADDI, ANDI
      add(6'h08, 1'b1, E_FRDY,  "addi_fetch");
      add(6'h08, 1'b1, E_DEC,   "addi_decode");
      add(6'h08, 1'b1, E_ADDI,  "addi_exec");
      add(6'h08, 1'b1, E_WBI,   "addi_wb");
      add(6'h0c, 1'b1, E_FRDY,  "andi_fetch");
      add(6'h0c, 1'b1, E_DEC,   "andi_decode");
      add(6'h0c, 1'b1, E_ANDI,  "andi_exec");
      add(6'h0c, 1'b1, E_WBI,   "andi_wb");
      // BEQ, J
      add(6'h04, 1'b1, E_FRDY,  "beq_fetch");
      add(6'h04, 1'b1, E_DEC,   "beq_decode");
      add(6'h04, 1'b1, E_BR,    "beq_branch");
      add(6'h02, 1'b1, E_FRDY,  "j_fetch");
      add(6'h02, 1'b1, E_DEC,   "j_decode");
      add(6'h02, 1'b1, E_JMP,   "j_jump");
      // SW with one wait in MEM_WRITE
      add(6'h2b, 1'b1, E_FRDY,  "sw_fetch");
      add(6'h2b, 1'b1, E_DEC,   "sw_decode");
      add(6'h2b, 1'b1, E_MADDR, "sw_addr");
      add(6'h2b, 1'b0, E_MWR,   "sw_write_w1");
      add(6'h2b, 1'b1, E_MWR,   "sw_write_rdy");
      // Illegal opcode: TRAP forever, no memory request
      add(6'h3f, 1'b1, E_FRDY,  "ill_fetch");
      add(6'h3f, 1'b1, E_DEC,   "ill_decode");
      for (int i = 0; i < 10; i++)
         add(6'h3f, 1'(i % 2), E_TRAP, $sformatf("ill_trap%0d", i));

      // Reset asserted asynchronously
      reset = 1'b1; Opcode = '0; MemReady = 1'b0; Zero = 1'b0;
      #1 reset = 1'b0;
      #1 check("reset_async", E_ZERO);
      @(negedge clk);
      @(negedge clk);
      check("reset_held", E_ZERO);
      reset    = 1'b1;
      MemReady = 1'b1;
      #1 check("idle_ignores_memready", E_ZERO);

      foreach (vq[i])
         step(vq[i].op, vq[i].mr, vq[i].exp, vq[i].name);

      // Reset clears the sticky Illegal flag immediately
      #2 reset = 1'b0;
      #1 check("trap_reset_clear", E_ZERO);
      @(negedge clk);
      reset = 1'b1; MemReady = 1'b0;
      #1 check("restart_idle", E_ZERO);
      step(6'h00, 1'b0, E_FWAIT, "restart_fetch");

      // Reset during a MEM_WRITE wait drops MemWrite in the same cycle
      step(6'h2b, 1'b1, E_FRDY,  "sw2_fetch");
      step(6'h2b, 1'b1, E_DEC,   "sw2_decode");
      step(6'h2b, 1'b1, E_MADDR, "sw2_addr");
      step(6'h2b, 1'b0, E_MWR,   "sw2_write_wait");
      #2 reset = 1'b0;
      #1 check_bit("sw2_reset_memwrite", MemWrite, 1'b0);
      check("sw2_reset_outputs", E_ZERO);
      @(negedge clk);
      reset = 1'b1;
      #1 check("sw2_restart_idle", E_ZERO);
      step(6'h00, 1'b0, E_FWAIT, "sw2_restart_fetch");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle main control unit: a state machine that sequences each MIPS instruction through fetch, decode, execute, memory and write-back, and drives the datapath control lines. It produces the 3-bit ALUOp consumed by the ALU control decoder. The unit sits beside the datapath, takes the latched opcode from the instruction register, and handshakes with a variable-latency unified memory.

## Interface
- Parameters: none. All encodings are fixed constants.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  rising-edge clock.
  - reset  in  1  asynchronous, active-low.
- Ports:
  - Opcode  in  6  instr[31:26] from the instruction register; valid from DECODE onward.
  - Zero  in  1  ALU zero flag.
  - MemReady  in  1  memory completed the access this cycle.
  - PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
  - ALUSrcB  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
  - PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target.
  - ALUOp  out  3  111=R-type (funct decides), 100=add, 101=or, 000=and, 001=branch compare.
  - Illegal  out  1  sticky; set on an unknown opcode.

## Operation
- States:
  - IDLE (reset only)
  - FETCH
  - DECODE
  - MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE
  - EXEC_R, EXEC_I, ALU_WB
  - BRANCH
  - JUMP
  - TRAP
- Opcodes:
  - R=000000, ADDI=001000, ORI=001101, ANDI=001100, BEQ=000100, J=000010, LW=100011, SW=101011.
- Any output not listed for a state is 0.
- Transitions and per-state outputs:
  - IDLE → FETCH unconditionally. All outputs are 0 in IDLE.
  - FETCH drives MemRead=1, ALUSrcB=1, ALUOp=100. It holds until MemReady=1. In the MemReady=1 cycle only, IRWrite=1 and PCWrite=1 (PC+4). The next state is DECODE.
  - DECODE drives ALUSrcB=3, ALUOp=100 (branch target into ALUOut). Next state by opcode:
    - LW/SW → MEM_ADDR
    - R → EXEC_R
    - ADDI/ORI/ANDI → EXEC_I
    - BEQ → BRANCH
    - J → JUMP
    - anything else → TRAP
  - MEM_ADDR drives ALUSrcA=1, ALUSrcB=2, ALUOp=100. Next state: MEM_READ for LW, MEM_WRITE for SW.
  - MEM_READ drives IorD=1, MemRead=1. It holds until MemReady, then goes to MEM_WB.
  - MEM_WB drives RegWrite=1, MemtoReg=1, RegDst=0, then → FETCH.
  - MEM_WRITE drives IorD=1, MemWrite=1. It holds until MemReady, then → FETCH.
  - EXEC_R drives ALUSrcA=1, ALUSrcB=0, ALUOp=111, then → ALU_WB.
  - EXEC_I drives ALUSrcA=1, ALUSrcB=2, and ALUOp=100/101/000 for ADDI/ORI/ANDI, then → ALU_WB.
  - ALU_WB drives RegWrite=1, MemtoReg=0, and RegDst=1 only if the latched class is R, then → FETCH.
    - The instruction class is latched in DECODE as a 2-bit register.
  - BRANCH drives ALUSrcA=1, ALUSrcB=0, ALUOp=001, PCWriteCond=1, PCSource=1, then → FETCH.
    - The PC updates when Zero=1; the datapath ANDs Zero with PCWriteCond.
  - JUMP drives PCWrite=1, PCSource=2, then → FETCH.
  - TRAP sets Illegal=1 and stays in TRAP until reset. All other outputs are 0.
- Outputs are combinational from the state register, the latched class and MemReady. Only FETCH gating uses MemReady (Mealy).

## Timing
- Reset asserted: state=IDLE immediately (asynchronous), all outputs 0, Illegal=0.
- Reset deasserts before a clk edge: the first edge moves to IDLE→FETCH; memory is first requested in cycle 2.
- Reset mid-instruction, including during a pending memory access: the access is abandoned, no write strobe stays asserted, and the outputs drop in the same cycle.
- Latency with MemReady tied high:
  - R/I-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - J: 3 cycles.
- Each MemReady=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- MemRead/MemWrite stay high and stable while waiting.
- MemReady asserted outside a memory state is ignored.
- Opcode is sampled only in DECODE and class is held to ALU_WB, so Opcode changes elsewhere are ignored.
- PCWrite and IRWrite are never high in the same cycle except FETCH-with-MemReady.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode constants
  - ALUOp encodings (must match the ALU control decoder's ALUOp values)
  - the state enum
  - ALUSrcB/PCSource encodings
- Sub-module control_output_decoder: a purely combinational map from {state, class, MemReady} to the output vector.
- The top holds the state register, next-state logic, class latch and Illegal flag.

## Test plan
- Reset, then MemReady=1, Opcode=000000 → state sequence FETCH, DECODE, EXEC_R, ALU_WB; ALUOp=111 in EXEC_R; RegDst=1 and RegWrite=1 in ALU_WB.
- Opcode=100011 with MemReady low 3 cycles in MEM_READ → MemRead and IorD held 3+1 cycles; total 8 cycles; RegWrite=1 with MemtoReg=1 once.
- Opcode=001101 (ORI) → ALUOp=101 in EXEC_I, ALUSrcB=2, RegDst=0 in ALU_WB.
- Opcode=000100 → BRANCH: PCWriteCond=1, PCSource=1, ALUOp=001; back to FETCH after 3 cycles.
- Opcode=111111 → Illegal=1 and remains set; MemRead stays 0 for 10 cycles; reset clears it.
- Assert reset during MEM_WRITE wait → MemWrite=0 in the same cycle; after release, sequence restarts IDLE→FETCH.
